// File: rtl/deser400_pkg.sv
// deser400_pkg: shared word width, arbiter FSM states and the buffered pair type.
package deser400_pkg;
    localparam int DESER_W = 16;
    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;
    typedef struct packed {
        logic [DESER_W-1:0] a;
        logic [DESER_W-1:0] b;
    } pair_t;
endpackage

// File: rtl/deser400_pairfifo.sv
// deser400_pairfifo: per-channel buffer of word pairs with a combinational head.
module deser400_pairfifo
    import deser400_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clock,
    input  logic  res_n,
    input  logic  push,
    input  logic  pop,
    input  logic  clear,
    input  pair_t din,
    output pair_t dout,
    output logic  full,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);
    pair_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    // a push into a full buffer is still taken when the head leaves in the same cycle
    assign do_push = push & ~clear & (~full | pop);
    assign do_pop = pop & ~empty & ~clear;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rptr];
    always_ff @(posedge clock or negedge res_n) begin
        if (!res_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= do_push ? wptr + 1'b1 : wptr;
            rptr <= do_pop ? rptr + 1'b1 : rptr;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/deser400_arbiter.sv
// deser400_arbiter: buffers deser400 word pairs per channel and emits them round-robin
// as two tagged words on one valid/ready stream, with sticky per-channel overflow flags.
module deser400_arbiter
    import deser400_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   res_n,
    input  logic                   run,
    input  logic                   clear,
    input  logic [NCH-1:0]         in_write,
    input  logic [DESER_W*NCH-1:0] in_data_a,
    input  logic [DESER_W*NCH-1:0] in_data_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DESER_W-1:0]     out_data,
    output logic [2:0]             out_chan,
    output logic                   out_last,
    output logic [NCH-1:0]         overflow
);
    localparam int GW = $clog2(NCH);
    pair_t dout [NCH];
    logic [NCH-1:0] push, pop, full, empty, rot;
    logic [GW-1:0] grant, last_grant, sel;
    logic [GW:0] off, sum;
    state_t state;
    assign push = in_write & {NCH{run & ~clear}};
    assign pop = (state == SEND_B && out_ready) ? NCH'(1) << grant : '0;
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        deser400_pairfifo #(.DEPTH(DEPTH)) u_fifo (
            .clock(clock),
            .res_n(res_n),
            .push (push[g]),
            .pop  (pop[g]),
            .clear(clear),
            .din  ({in_data_a[DESER_W*g +: DESER_W], in_data_b[DESER_W*g +: DESER_W]}),
            .dout (dout[g]),
            .full (full[g]),
            .empty(empty[g])
        );
    end
    // rotate the non-empty mask so bit 0 is the channel after last_grant, then take the lowest set bit
    always_comb begin
        rot = NCH'({~empty, ~empty} >> ({1'b0, last_grant} + 1'b1));
        off = '0;
        for (int j = NCH - 1; j >= 0; j--) if (rot[j]) off = (GW+1)'(j);
        sum = {1'b0, last_grant} + (GW+1)'(1) + off;
        sel = GW'(sum >= (GW+1)'(NCH) ? sum - (GW+1)'(NCH) : sum);
    end
    always_ff @(posedge clock or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_data <= '0;
            out_chan <= '0;
            out_last <= 1'b0;
            overflow <= '0;
            grant <= '0;
            last_grant <= GW'(NCH - 1);
        end else if (clear) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            overflow <= '0;
        end else begin
            overflow <= overflow | (push & full & ~pop);
            case (state)
                IDLE: if (!(&empty)) begin
                    state <= SEND_A;
                    out_valid <= 1'b1;
                    grant <= sel;
                    out_chan <= 3'(sel);
                    out_data <= dout[sel].a;
                    out_last <= 1'b0;
                end
                SEND_A: if (out_ready) begin
                    state <= SEND_B;
                    out_data <= dout[grant].b;
                    out_last <= 1'b1;
                end
                SEND_B: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    last_grant <= grant;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_deser400_arbiter.sv
// tb_deser400_arbiter: directed plan plus random traffic, checked every cycle against
// a queue-based reference of the merging behaviour.
module tb_deser400_arbiter;
    localparam int NCH = 4;
    localparam int DEPTH = 4;
    logic clock = 1'b0, res_n = 1'b0, run = 1'b1, clear = 1'b0, out_ready = 1'b1;
    logic [NCH-1:0] in_write = '0;
    logic [16*NCH-1:0] in_data_a = '0, in_data_b = '0;
    logic out_valid, out_last;
    logic [15:0] out_data;
    logic [2:0] out_chan;
    logic [NCH-1:0] overflow;
    always #5 clock = ~clock;
    deser400_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .clock(clock), .res_n(res_n), .run(run), .clear(clear),
        .in_write(in_write), .in_data_a(in_data_a), .in_data_b(in_data_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_last(out_last), .overflow(overflow)
    );
    int n_chk = 0, n_fail = 0;
    // reference: per-channel pair queues, the pair in flight (phase 0 idle, 1 a-word, 2 b-word)
    logic [31:0] mq [NCH][$];
    int m_phase = 0, m_chan = 0, m_last = NCH - 1;
    logic [NCH-1:0] m_ovf = '0;
    int log_q [$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic model_edge();
        int pre [NCH];
        int pop_ch, g;
        logic [31:0] dummy;
        pop_ch = -1;
        g = -1;
        for (int i = 0; i < NCH; i++) pre[i] = mq[i].size();
        if (clear) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            m_ovf = '0;
            m_phase = 0;
            return;
        end
        if (m_phase == 2 && out_ready) pop_ch = m_chan;
        if (m_phase == 0)
            for (int k = 1; k <= NCH; k++)
                if (g < 0 && pre[(m_last + k) % NCH] > 0) g = (m_last + k) % NCH;
        if (pop_ch >= 0) begin
            dummy = mq[pop_ch].pop_front();
            m_last = pop_ch;
            m_phase = 0;
        end else if (m_phase == 1 && out_ready) m_phase = 2;
        for (int i = 0; i < NCH; i++)
            if (in_write[i] && run) begin
                if (pre[i] < DEPTH || pop_ch == i)
                    mq[i].push_back({in_data_a[16*i +: 16], in_data_b[16*i +: 16]});
                else m_ovf[i] = 1'b1;
            end
        if (g >= 0) begin
            m_phase = 1;
            m_chan = g;
        end
    endtask
    task automatic check_out();
        logic [31:0] p;
        chk("valid", out_valid, m_phase != 0);
        if (m_phase != 0) begin
            p = mq[m_chan][0];
            chk("data", out_data, m_phase == 1 ? p[31:16] : p[15:0]);
            chk("chan", out_chan, m_chan);
            chk("last", out_last, m_phase == 2);
        end
        chk("ovf", overflow, m_ovf);
    endtask
    task automatic step();
        if (out_valid && out_ready && out_last) log_q.push_back(int'(out_chan));
        @(posedge clock);
        model_edge();
        #1;
        check_out();
    endtask
    task automatic wr(input int ch, input logic [15:0] a, input logic [15:0] b);
        in_write[ch] = 1'b1;
        in_data_a[16*ch +: 16] = a;
        in_data_b[16*ch +: 16] = b;
        step();
        in_write = '0;
    endtask
    function automatic bit model_busy();
        bit r = m_phase != 0;
        for (int i = 0; i < NCH; i++) if (mq[i].size() != 0) r = 1'b1;
        return r;
    endfunction
    task automatic drain(input int budget);
        int n = 0;
        out_ready = 1'b1;
        while ((out_valid || model_busy()) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", n < budget, 1'b1);
    endtask
    task automatic do_reset();
        in_write = '0;
        clear = 1'b0;
        run = 1'b1;
        @(negedge clock);
        res_n = 1'b0;
        for (int i = 0; i < NCH; i++) mq[i].delete();
        m_phase = 0;
        m_last = NCH - 1;
        m_ovf = '0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clock);
        res_n = 1'b1;
    endtask
    initial begin
        int n;
        int exp_rr [4] = '{0, 1, 2, 3};
        do_reset();
        // single write, latency 2
        out_ready = 1'b1;
        wr(2, 16'h1234, 16'hABCD);
        chk("lat_c1_valid", out_valid, 0);
        step();
        chk("lat_valid", out_valid, 1);
        chk("lat_a", out_data, 16'h1234);
        chk("lat_chan", out_chan, 2);
        chk("lat_last_a", out_last, 0);
        step();
        chk("lat_b", out_data, 16'hABCD);
        chk("lat_last_b", out_last, 1);
        step();
        chk("lat_end", out_valid, 0);
        // round-robin from reset
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            in_data_a[16*i +: 16] = 16'(16'h1000 + i);
            in_data_b[16*i +: 16] = 16'(16'h2000 + i);
        end
        in_write = '1;
        step();
        in_write = '0;
        log_q.delete();
        drain(60);
        chk("rr_cnt", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", log_q.size() > i ? log_q[i] : -1, exp_rr[i]);
        in_write = 4'b1010;
        step();
        in_write = '0;
        log_q.delete();
        drain(40);
        chk("rr2_cnt", log_q.size(), 2);
        chk("rr2_first", log_q.size() > 0 ? log_q[0] : -1, 1);
        chk("rr2_second", log_q.size() > 1 ? log_q[1] : -1, 3);
        // backpressure during SEND_A
        out_ready = 1'b0;
        wr(0, 16'hBEEF, 16'hCAFE);
        n = 0;
        while (!out_valid && n < 5) begin step(); n++; end
        chk("bp_granted", out_valid, 1);
        for (int i = 0; i < 10; i++) step();
        chk("bp_held_a", out_data, 16'hBEEF);
        drain(20);
        // overflow on channel 1
        out_ready = 1'b0;
        for (int p = 1; p <= 5; p++) wr(1, 16'(16'h0100 + p), 16'(16'h0200 + p));
        step();
        chk("ovf_flag", overflow, 4'b0010);
        log_q.delete();
        drain(40);
        chk("ovf_pairs", log_q.size(), 4);
        // full buffer with a concurrent pop
        out_ready = 1'b0;
        for (int p = 0; p < 4; p++) wr(0, 16'(16'h5000 + p), 16'(16'h5100 + p));
        log_q.delete();
        out_ready = 1'b1;
        step();
        chk("fp_in_b", out_last, 1);
        wr(0, 16'h5EEE, 16'h5FFF);
        chk("fp_ovf0", overflow[0], 0);
        drain(40);
        chk("fp_pairs", log_q.size(), 5);
        // clear in SEND_B
        in_write = 4'b0011;
        step();
        in_write = '0;
        n = 0;
        while (!(out_valid && out_last) && n < 10) begin step(); n++; end
        chk("clr_in_b", out_last, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_ovf", overflow, 0);
        for (int i = 0; i < 5; i++) step();
        // last_grant survives clear
        in_write = 4'b0011;
        step();
        in_write = '0;
        log_q.delete();
        drain(40);
        chk("clr_rr", log_q.size() > 0 ? log_q[0] : -1, 1);
        // run = 0 blocks pushes
        run = 1'b0;
        in_write = '1;
        step();
        step();
        in_write = '0;
        for (int i = 0; i < 4; i++) step();
        chk("run0_valid", out_valid, 0);
        run = 1'b1;
        // random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NCH; i++) begin
                in_write[i] = $urandom_range(0, 9) < 3;
                in_data_a[16*i +: 16] = 16'($urandom);
                in_data_b[16*i +: 16] = 16'($urandom);
            end
            out_ready = $urandom_range(0, 3) != 0;
            run = $urandom_range(0, 19) != 0;
            clear = $urandom_range(0, 149) == 0;
            step();
        end
        in_write = '0;
        clear = 1'b0;
        run = 1'b1;
        drain(200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/deser400_arbiter.md
# deser400_arbiter

Merges the parallel outputs of NCH deser400 channels onto one 16-bit valid/ready stream toward the readout FIFO. Each channel's `write` strobe delivers a word pair (`data_a`, `data_b`). The arbiter buffers pairs per channel, grants channels round-robin, and emits each pair as two consecutive tagged words. Per-channel sticky overflow flags report dropped pairs.

## Interface
- `NCH`, 4: number of deser400 channels, 2..8.
- `DEPTH`, 4: per-channel buffer depth in word pairs; power of 2, at least 2.
- `clock`  in  1  system clock; same clock as the deser400 instances.
- `res_n`  in  1  reset, asynchronous and active-low.
- `run`  in  1  1 = accept channel writes; 0 = ignore writes, keep draining.
- `clear`  in  1  synchronous flush of buffers, overflow flags and FSM.
- `in_write`  in  NCH  per-channel pair strobe.
- `in_data_a`  in  16*NCH  channel i on bits [16i+15:16i].
- `in_data_b`  in  16*NCH  same packing as `in_data_a`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  16  output word.
- `out_chan`  out  3  source channel of `out_data`.
- `out_last`  out  1  1 on the b-word of a pair.
- `overflow`  out  NCH  sticky; a pair was dropped on channel i.

## Operation
- Push: `in_write[i]` & `run` & !`clear` writes {a,b} into buffer i.
  - If buffer i is full and no pop of i happens in the same cycle, the pair is dropped and `overflow[i]` is set.
  - Full with a simultaneous pop: the push is accepted and the occupancy is unchanged.
- FSM states: IDLE, SEND_A, SEND_B.
  - IDLE: if any buffer is non-empty, grant the first non-empty channel searching from `last_grant`+1 modulo NCH. Go to SEND_A with `out_valid`=1, `out_data`=a, `out_chan`=grant, `out_last`=0.
  - SEND_A: on `out_valid`&`out_ready`, go to SEND_B with `out_data`=b and `out_last`=1.
  - SEND_B: on handshake, pop buffer[grant], set `last_grant`=grant, go to IDLE with `out_valid`=0.
- All outputs are registered. While `out_valid`=1 and `out_ready`=0, `out_data`, `out_chan` and `out_last` are held stable.
- `clear` has priority over everything. In the next cycle:
  - all buffers are empty and `overflow`=0;
  - the FSM is in IDLE with `out_valid`=0, even mid-pair (the pair is aborted);
  - `last_grant` is unchanged.
- `run`=0 blocks pushes only. Arbitration and draining continue.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `out_last`=0, `overflow`=0, buffers empty, FSM in IDLE, `last_grant`=NCH-1, so channel 0 wins first.
- Latency, `in_write` to `out_valid`, with empty buffers and the FSM in IDLE: 2 cycles. Cycle 1: buffer write. Cycle 2: grant registered.
- Throughput: one pair per 3 cycles with `out_ready` held high (A, B, IDLE bubble). This exceeds the aggregate deser400 pair rate for NCH ≤ 8.
- Pointers wrap modulo DEPTH. Full and empty are derived from a (log2 DEPTH + 1)-bit occupancy count per channel.
- `overflow` is set in the cycle after the dropped strobe.

## Structure
- Package `deser400_pkg`: `DESER_W`=16, the FSM state enum (IDLE, SEND_A, SEND_B), and the 32-bit pair typedef {a,b}.
- Sub-module `deser400_pairfifo`: one per channel, DEPTH × 32 bits.
  - Ports: push, pop, clear, din, dout, full, empty.
  - `dout` is combinational from the read pointer.
- The top level holds the round-robin grant logic, the FSM, the output registers and the overflow flags.

## Test plan
- **Reset then single write.** Apply reset; then `in_write[2]`, a=0x1234, b=0xABCD, `out_ready`=1. Required: `out_valid` 2 cycles later with 0x1234/chan 2/last 0, then 0xABCD/last 1, then `out_valid`=0.
- **Round-robin.** Write one pair to each of channels 0..3 in the same cycle. Required: output channel order 0,1,2,3. Then write channels 3 and 1 again. Required: order 1, then 3.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles during SEND_A. Required: `out_data`, `out_chan` and `out_last` stay constant and no pop occurs. After `out_ready`=1, the pair completes intact.
- **Overflow.** `out_ready`=0; write 5 pairs to channel 1 with DEPTH=4. Required: `overflow[1]`=1 and the other flags stay 0. After release, exactly pairs 1..4 are emitted.
- **Full with concurrent pop.** Channel 0 buffer full; push coincides with the SEND_B handshake. Required: no overflow, and the new pair is emitted last.
- **Clear and run.**
  - Assert `clear` in SEND_B. Required: next cycle `out_valid`=0, all buffers empty, `overflow`=0.
  - With `run`=0, writes on all channels produce no output.
